// File: rtl/fifo_pkg.sv
// Helpers shared by the FIFO family: sizing functions and parameter legality checks.
package fifo_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit thresh_ok(input int af, input int ae, input int depth);
    return (af >= 0) && (af <= depth) && (ae >= 0) && (ae <= depth);
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Storage array with one write port and one registered read port; contents are not reset.
module fifo_ram_dp #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error bits and flush.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 2,
  localparam int ADDR_W    = clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE    = PW'(1);
  localparam logic [PW-1:0] FULL_C = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_C   = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_C   = PW'(AE_THRESH);

  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("fifo_sync_flags: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!thresh_ok(AF_THRESH, AE_THRESH, FIFO_DEPTH)) begin : g_bad_thresh
    $error("fifo_sync_flags: thresholds must lie within 0..FIFO_DEPTH");
  end

  logic [PW-1:0] wr_ptr, rd_ptr, count_nxt;
  logic          rd_ok, wr_ok, ovf_set, udf_set;

  always_comb begin
    rd_ok   = cs & rd_en & ~empty & ~flush;
    wr_ok   = cs & wr_en & ~flush & (~full | rd_ok);
    ovf_set = cs & wr_en & full & ~rd_ok & ~flush;
    udf_set = cs & rd_en & empty & ~flush;
    count_nxt = count;
    if (flush)                count_nxt = '0;
    else if (wr_ok && !rd_ok) count_nxt = count + ONE;
    else if (rd_ok && !wr_ok) count_nxt = count - ONE;
  end

  // At full with a same-cycle read, both indices match; the read port samples the old word.
  fifo_ram_dp #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .re    (rd_ok),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (data_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + ONE;
        if (rd_ok) rd_ptr <= rd_ptr + ONE;
      end
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == FULL_C);
      almost_empty <= (count_nxt <= AE_C);
      almost_full  <= (count_nxt >= AF_C);
      overflow     <= ovf_set | (overflow & ~err_clr);
      underflow    <= udf_set | (underflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed-vector bench for fifo_sync_flags at DEPTH=8, WIDTH=32, AF=6, AE=2.
module tb_fifo_sync_flags;

  logic        clk;
  logic        rst_n;
  logic        cs, wr_en, rd_en, flush, err_clr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        empty, full, almost_empty, almost_full, overflow, underflow;
  logic [3:0]  count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  fifo_sync_flags #(
    .FIFO_DEPTH (8),
    .DATA_WIDTH (32),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .flush        (flush),
    .err_clr      (err_clr),
    .data_in      (data_in),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".data_out"}, data_out, 0);
    check({tag, ".count"}, 32'(count), 0);
    check({tag, ".empty"}, 32'(empty), 1);
    check({tag, ".ae"}, 32'(almost_empty), 1);
    check({tag, ".full"}, 32'(full), 0);
    check({tag, ".af"}, 32'(almost_full), 0);
    check({tag, ".ovf"}, 32'(overflow), 0);
    check({tag, ".udf"}, 32'(underflow), 0);
  endtask

  task automatic op(input logic c, input logic w, input logic r, input logic f,
                    input logic e, input logic [31:0] d);
    cs = c; wr_en = w; rd_en = r; flush = f; err_clr = e; data_in = d;
    @(posedge clk);
    #1;
    cs = 0; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; data_in = '0;
  endtask

  task automatic wr(input logic [31:0] d);
    op(1, 1, 0, 0, 0, d);
  endtask

  task automatic rd();
    op(1, 0, 1, 0, 0, 0);
  endtask

  initial begin
    cs = 0; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0; data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;

    // 1: basic write/read ordering
    wr(1); wr(10); wr(100);
    check("t1.count", 32'(count), 3);
    rd(); check("t1.rd0", data_out, 1);
    rd(); check("t1.rd1", data_out, 10);
    rd(); check("t1.rd2", data_out, 100);
    check("t1.empty", 32'(empty), 1);
    check("t1.udf", 32'(underflow), 0);

    // 2: fill past full
    for (int i = 0; i < 8; i++) wr(32'd1 << i);
    check("t2.full8", 32'(full), 1);
    check("t2.ovf_pre", 32'(overflow), 0);
    wr(32'd256);
    check("t2.full", 32'(full), 1);
    check("t2.ovf", 32'(overflow), 1);
    check("t2.count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      rd();
      check($sformatf("t2.rd%0d", i), data_out, 32'd1 << i);
    end
    check("t2.empty", 32'(empty), 1);
    check("t2.ovf_sticky", 32'(overflow), 1);
    op(1, 0, 0, 0, 1, 0);
    check("t2.ovf_clr", 32'(overflow), 0);

    // 3: simultaneous read/write at full
    for (int i = 0; i < 8; i++) wr(32'h100 + 32'(i));
    op(1, 1, 1, 0, 0, 32'hAA);
    check("t3.count", 32'(count), 8);
    check("t3.full", 32'(full), 1);
    check("t3.dout", data_out, 32'h100);
    check("t3.ovf", 32'(overflow), 0);
    for (int i = 1; i < 8; i++) begin
      rd();
      check($sformatf("t3.rd%0d", i), data_out, 32'h100 + 32'(i));
    end
    rd();
    check("t3.last", data_out, 32'hAA);
    check("t3.empty", 32'(empty), 1);

    // 4: simultaneous read/write when empty
    op(1, 1, 1, 0, 0, 32'd5);
    check("t4.udf", 32'(underflow), 1);
    check("t4.count", 32'(count), 1);
    check("t4.dout_hold", data_out, 32'hAA);
    rd();
    check("t4.rd", data_out, 5);
    check("t4.udf_sticky", 32'(underflow), 1);
    op(1, 0, 0, 0, 1, 0);
    check("t4.udf_clr", 32'(underflow), 0);

    // 5: thresholds and flush
    wr(32'h10); wr(32'h11); wr(32'h12);
    check("t5.ae3", 32'(almost_empty), 0);
    check("t5.af3", 32'(almost_full), 0);
    wr(32'h13); wr(32'h14);
    check("t5.af5", 32'(almost_full), 0);
    wr(32'h15);
    check("t5.count6", 32'(count), 6);
    check("t5.af6", 32'(almost_full), 1);
    rd(); check("t5.af5b", 32'(almost_full), 0);
    rd(); rd();
    check("t5.ae3b", 32'(almost_empty), 0);
    rd();
    check("t5.count2", 32'(count), 2);
    check("t5.ae2", 32'(almost_empty), 1);
    check("t5.dout", data_out, 32'h13);
    wr(32'h20); wr(32'h21); wr(32'h22);
    check("t5.count5", 32'(count), 5);
    op(1, 1, 1, 1, 0, 32'h77);
    check("t5.fl_count", 32'(count), 0);
    check("t5.fl_empty", 32'(empty), 1);
    check("t5.fl_dout", data_out, 32'h13);
    check("t5.fl_udf", 32'(underflow), 0);
    wr(32'h30);
    op(0, 0, 0, 1, 0, 0);
    check("t5.fl_cs0", 32'(count), 0);
    op(0, 0, 1, 0, 0, 0);
    check("t5.cs0_udf", 32'(underflow), 0);
    wr(32'h31);
    rd();
    check("t5.after_fl", data_out, 32'h31);

    // 6: asynchronous reset mid-burst, then error clear behaviour
    for (int i = 0; i < 4; i++) wr(32'h50 + 32'(i));
    check("t6.count4", 32'(count), 4);
    #2 rst_n = 1'b0;
    #1 check_reset("t6.rst");
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) wr(32'h40 + 32'(i));
    op(0, 1, 0, 0, 0, 32'h98);
    check("t6.cs0_ovf", 32'(overflow), 0);
    wr(32'h99);
    check("t6.ovf", 32'(overflow), 1);
    op(1, 1, 0, 0, 1, 32'h9A);
    check("t6.set_wins", 32'(overflow), 1);
    op(1, 0, 0, 0, 1, 0);
    check("t6.clr", 32'(overflow), 0);
    rd();
    check("t6.rd", data_out, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
